// File: rtl/serial_tx_param_pkg.sv
// Shared types and helpers for the parametrised serial transmitter.
package serial_tx_param_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SHIFT   = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  // Bits on the line for one frame: start + data + optional parity + stop(s).
  function automatic int unsigned frame_bits(input int unsigned data_w,
                                             input int unsigned parity_mode,
                                             input int unsigned stop_bits);
    return 1 + data_w + ((parity_mode != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

  function automatic int unsigned frame_len(input int unsigned data_w,
                                            input int unsigned parity_mode,
                                            input int unsigned stop_bits,
                                            input int unsigned clk_div);
    return frame_bits(data_w, parity_mode, stop_bits) * clk_div;
  endfunction

endpackage

// File: rtl/serial_tx_param_if.sv
// Host/line-side signal bundle of the serial transmitter.
interface serial_tx_param_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic              send;
  logic [DATA_W-1:0] d;
  logic              ack;
  logic              RTS;
  logic              TX;
  logic              PD;
  logic              busy;
  logic              done;
  logic              err;

  modport master (output send, d, ack, input RTS, TX, PD, busy, done, err);
  modport slave  (input send, d, ack, output RTS, TX, PD, busy, done, err);
endinterface

// File: rtl/serial_tx_baudgen.sv
// Bit-period divider: free-runs 0..CLK_DIV-1 while enabled, strobes on wrap.
module serial_tx_baudgen #(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_tick_c
);
  localparam int unsigned CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    bit_tick_c = (cnt_q == CNT_W'(CLK_DIV - 1));
    cnt_d      = cnt_q + CNT_W'(1);
    if (clr || bit_tick_c) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/serial_tx_param.sv
// Parametrised framed serial transmitter with RTS/ACK line request,
// ACK timeout abort and a frame-complete pulse.
module serial_tx_param
  import serial_tx_param_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned PARITY_MODE = 1,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned CLK_DIV     = 16,
  parameter int unsigned LSB_FIRST   = 1,
  parameter int unsigned ACK_TIMEOUT = 1024
) (
  input logic              clk,
  input logic              rst,
  serial_tx_param_if.slave bus
);
  localparam int unsigned FRAME_BITS = frame_bits(DATA_W, PARITY_MODE, STOP_BITS);
  localparam int unsigned SHIFT_W    = FRAME_BITS - 1;
  localparam int unsigned BIT_CNT_W  = $clog2(DATA_W + 4);
  localparam int unsigned TMO_W      = $clog2(ACK_TIMEOUT + 1);

  state_e               state_q, state_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [SHIFT_W-1:0]   shift_q, shift_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 rts_q, rts_d;
  logic                 tx_q, tx_d;
  logic                 pd_q, pd_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic                 bit_tick_c;
  logic [DATA_W-1:0]    ordered_c;
  logic                 parity_c;
  logic [SHIFT_W-1:0]   load_c;

  serial_tx_baudgen #(.CLK_DIV(CLK_DIV)) u_baudgen (
    .clk        (clk),
    .rst        (rst),
    .clr        (state_q != ST_SHIFT),
    .bit_tick_c (bit_tick_c)
  );

  // Everything after the start bit, in transmit order from bit 0 upward.
  always_comb begin
    ordered_c = '0;
    for (int unsigned i = 0; i < DATA_W; i++)
      ordered_c[i] = (LSB_FIRST != 0) ? data_q[i] : data_q[DATA_W-1-i];
    parity_c = (PARITY_MODE == PAR_ODD)  ? ~^data_q :
               (PARITY_MODE == PAR_EVEN) ?  ^data_q : 1'b0;
  end

  if (PARITY_MODE != PAR_NONE) begin : g_par
    assign load_c = {{STOP_BITS{1'b1}}, parity_c, ordered_c};
  end else begin : g_nopar
    assign load_c = {{STOP_BITS{1'b1}}, ordered_c};
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tmo_d     = tmo_q;
    rts_d     = rts_q;
    tx_d      = tx_q;
    pd_d      = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        rts_d = 1'b0;
        tx_d  = 1'b1;
        if (bus.send) begin
          data_d  = bus.d;
          tmo_d   = '0;
          pd_d    = 1'b1;
          rts_d   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // ack is checked first so it wins over an expiring timeout
        if (bus.ack) begin
          shift_d   = load_c;
          bit_cnt_d = '0;
          tx_d      = 1'b0;
          state_d   = ST_SHIFT;
        end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          rts_d   = 1'b0;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_SHIFT: begin
        if (bit_tick_c) begin
          if (bit_cnt_q == BIT_CNT_W'(FRAME_BITS - 1)) begin
            done_d  = 1'b1;
            rts_d   = 1'b0;
            tx_d    = 1'b1;
            state_d = ST_RELEASE;
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end
      ST_RELEASE: begin
        if (!bus.ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tmo_q     <= '0;
      rts_q     <= 1'b0;
      tx_q      <= 1'b1;
      pd_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tmo_q     <= tmo_d;
      rts_q     <= rts_d;
      tx_q      <= tx_d;
      pd_q      <= pd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.RTS  = rts_q;
  assign bus.TX   = tx_q;
  assign bus.PD   = pd_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;
endmodule

// File: tb/tb_serial_tx_param.sv
// Four transmitter configurations driven in lockstep and checked against
// frames built directly from the word, parity rule and bit order.
module tb_serial_tx_param;
  localparam int unsigned NCFG  = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned CDIV  = 4;
  localparam int unsigned TMO   = 10;
  localparam int unsigned NBITS = 11;
  localparam int unsigned FCYC  = NBITS * CDIV;

  // cfg0: odd/1 stop/LSB, cfg1: even, cfg2: no parity/2 stops, cfg3: odd/MSB first
  function automatic int unsigned cfg_par(input int g);
    return (g == 1) ? 2 : ((g == 2) ? 0 : 1);
  endfunction
  function automatic int unsigned cfg_stop(input int g);
    return (g == 2) ? 2 : 1;
  endfunction
  function automatic int unsigned cfg_lsb(input int g);
    return (g == 3) ? 0 : 1;
  endfunction

  logic clk = 1'b0;
  logic rst, send, ack;
  logic [DW-1:0] d;
  logic tx_o [NCFG];
  logic rts_o [NCFG];
  logic pd_o [NCFG];
  logic busy_o [NCFG];
  logic done_o [NCFG];
  logic err_o [NCFG];

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    serial_tx_param_if #(.DATA_W(DW)) bus ();
    assign bus.send = send;
    assign bus.d    = d;
    assign bus.ack  = ack;
    assign tx_o[g]   = bus.TX;
    assign rts_o[g]  = bus.RTS;
    assign pd_o[g]   = bus.PD;
    assign busy_o[g] = bus.busy;
    assign done_o[g] = bus.done;
    assign err_o[g]  = bus.err;

    serial_tx_param #(
      .DATA_W      (DW),
      .PARITY_MODE (cfg_par(g)),
      .STOP_BITS   (cfg_stop(g)),
      .CLK_DIV     (CDIV),
      .LSB_FIRST   (cfg_lsb(g)),
      .ACK_TIMEOUT (TMO)
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  // Expected line level for frame bit idx of word w under configuration g.
  function automatic logic exp_bit(input int g, input logic [DW-1:0] w, input int idx);
    int ones = $countones(w);
    if (idx == 0) return 1'b0;
    if (idx <= int'(DW)) return (cfg_lsb(g) != 0) ? w[idx-1] : w[int'(DW)-idx];
    if (cfg_par(g) != 0 && idx == int'(DW) + 1)
      return (cfg_par(g) == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
    return 1'b1;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_all(input string where, input logic e_tx, input logic e_rts,
                           input logic e_pd, input logic e_busy, input logic e_done,
                           input logic e_err);
    for (int g = 0; g < int'(NCFG); g++) begin
      check_eq($sformatf("%s.cfg%0d.tx", where, g),   32'(tx_o[g]),   32'(e_tx));
      check_eq($sformatf("%s.cfg%0d.rts", where, g),  32'(rts_o[g]),  32'(e_rts));
      check_eq($sformatf("%s.cfg%0d.pd", where, g),   32'(pd_o[g]),   32'(e_pd));
      check_eq($sformatf("%s.cfg%0d.busy", where, g), 32'(busy_o[g]), 32'(e_busy));
      check_eq($sformatf("%s.cfg%0d.done", where, g), 32'(done_o[g]), 32'(e_done));
      check_eq($sformatf("%s.cfg%0d.err", where, g),  32'(err_o[g]),  32'(e_err));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; send = 1'b0; ack = 1'b0; d = '0;
    step(); step();
    check_all("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    check_all("post_reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One full transaction; noise adds ignored sends, changing d and ack wiggle.
  task automatic run_frame(input logic [DW-1:0] w, input int ack_dly, input bit noise);
    int hold;
    send = 1'b1; d = w; ack = 1'b0;
    step();
    send = 1'b0; d = DW'($urandom);
    check_all("accept", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < ack_dly; i++) begin
      ack = 1'b0;
      send = noise ? 1'($urandom) : 1'b0;
      step();
      check_all("req", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    ack = 1'b1; send = 1'b0;
    step();
    for (int c = 0; c < int'(FCYC); c++) begin
      for (int g = 0; g < int'(NCFG); g++) begin
        check_eq($sformatf("frame.cfg%0d.c%0d.tx", g, c), 32'(tx_o[g]),
                 32'(exp_bit(g, w, c / int'(CDIV))));
        check_eq($sformatf("frame.cfg%0d.c%0d.done", g, c), 32'(done_o[g]), 32'd0);
      end
      check_eq("frame.rts", 32'(rts_o[0]), 32'd1);
      check_eq("frame.busy", 32'(busy_o[2]), 32'd1);
      if (noise) begin
        send = 1'($urandom); d = DW'($urandom); ack = 1'($urandom);
      end
      step();
    end
    check_all("done", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    hold = noise ? int'($urandom_range(1, 3)) : 0;
    ack = 1'b1; send = noise;
    for (int i = 0; i < hold; i++) begin
      step();
      check_all("release", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    ack = 1'b0;
    step();
    send = 1'b0;
    check_all("to_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_timeout(input logic [DW-1:0] w);
    send = 1'b1; d = w; ack = 1'b0;
    step();
    send = 1'b0;
    check_all("tmo_accept", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < int'(TMO); i++) begin
      step();
      check_all("tmo_wait", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    step();
    check_all("tmo_err", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    check_all("tmo_after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_reset_mid(input logic [DW-1:0] w);
    send = 1'b1; d = w; ack = 1'b1;
    step();
    send = 1'b0;
    step();
    for (int c = 0; c < 5 * int'(CDIV) + 2; c++) step();
    for (int g = 0; g < int'(NCFG); g++)
      check_eq($sformatf("mid.cfg%0d.tx", g), 32'(tx_o[g]), 32'(exp_bit(g, w, 5)));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all("rst_mid", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_all("rst_quiet", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; send = 1'b0; ack = 1'b0; d = '0;
    do_reset();
    run_frame(8'hA5, 0, 1'b0);
    run_frame(8'hA5, 3, 1'b1);
    run_timeout(DW'($urandom));
    run_frame(DW'($urandom), int'(TMO) - 1, 1'b1);
    run_reset_mid(8'hA5);
    run_frame(8'hA5, 0, 1'b0);
    for (int k = 0; k < 6; k++)
      run_frame(DW'($urandom), int'($urandom_range(0, TMO - 1)), 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/serial_tx_param.md
Name: serial_tx_param

Overview:
Parametrised next-generation serial transmitter: latches a DATA_W-bit word, requests the line via RTS/ACK handshake, then shifts out a framed word (start, data, optional parity, 1 or 2 stop bits) at a divided bit rate. Replaces the fixed 8-bit FSM/counter/shift-register/parity/latch cluster with one configurable block. Adds an ACK timeout and a completion flag.

Parameters:
DATA_W, 8, data bits per frame (2..32)
PARITY_MODE, 1, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame (1 or 2)
CLK_DIV, 16, clk cycles per bit (>=2)
LSB_FIRST, 1, 1 = d[0] sent first, 0 = d[DATA_W-1] first
ACK_TIMEOUT, 1024, clk cycles to wait for ack before abort (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
send  in  1  request to transmit d; sampled only in IDLE
d  in  DATA_W  parallel data word
ack  in  1  line grant from receiver
RTS  out  1  request-to-send
TX  out  1  serial line, idle high
PD  out  1  one-cycle pulse: d captured into latch
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse: frame fully sent
err  out  1  one-cycle pulse: ACK timeout abort

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; RTS=0, TX=1, PD=0, busy=0, done=0, err=0; counters and latch cleared. Applies mid-frame: TX returns high the next cycle, no done/err.
- States: IDLE, REQ, SHIFT, RELEASE.
- IDLE: on send=1 at edge N, latch d, compute parity, load shift register; at N+1 PD=1 (one cycle), RTS=1, busy=1, state=REQ. send while busy is ignored (no queueing).
- REQ: timeout counter increments each cycle. ack=1 sampled at edge K -> state=SHIFT, start bit on TX from K+1. If ACK_TIMEOUT cycles elapse without ack: err pulse, RTS=0, state=IDLE. ack and timeout in the same cycle: ack wins.
- SHIFT: frame order is start(0), DATA_W data bits in LSB_FIRST order, parity bit if PARITY_MODE!=0, then STOP_BITS ones. Each bit is held exactly CLK_DIV cycles (baud counter 0..CLK_DIV-1; bit advances on wrap). Frame length F=(1+DATA_W+(PARITY_MODE!=0)+STOP_BITS)*CLK_DIV cycles. ack dropping mid-frame is ignored; the frame always completes.
- Parity: odd -> bit set so total data ones + parity is odd; even -> total even. Computed from the latched word, not live d.
- End of last stop bit: done=1 for one cycle, RTS=0, TX=1, state=RELEASE.
- RELEASE: wait for ack=0 (four-phase), then IDLE. If ack is already 0, IDLE the next cycle. send during RELEASE is ignored.
- Bit counter width is clog2(DATA_W+4); baud counter width is clog2(CLK_DIV). Neither wraps within a frame.

Decomposition:
- Shared package: state encoding (IDLE/REQ/SHIFT/RELEASE), parity-mode constants (PAR_NONE/PAR_ODD/PAR_EVEN), and a frame-length function.
- One natural sub-module, serial_tx_baudgen: CLK_DIV counter with sync clear, producing a bit_tick strobe.
- FSM, shift register and parity logic stay in the top.

Test Plan:
- DATA_W=8, PARITY_MODE=1, CLK_DIV=4, LSB_FIRST=1; send with d=8'hA5, ack tied high -> PD pulse at N+1; TX sequence 0,1,0,1,0,0,1,0,1,1(parity),1(stop), each held 4 cycles (44 cycles total); done pulses once; RTS=0 afterwards.
- Same stimulus with PARITY_MODE=2 -> parity bit 0; with PARITY_MODE=0, STOP_BITS=2 -> 11 bits with no parity and two stop bits; LSB_FIRST=0 -> data bits 1,0,1,0,0,1,0,1 in MSB-first order.
- ACK_TIMEOUT=10, ack held low -> RTS high for 10 cycles, then one err pulse, RTS=0, TX stays 1, busy=0, no done.
- Second send issued during SHIFT with a different d -> ignored; only one frame is sent and the latch keeps 8'hA5.
- rst=1 mid data bit 4 -> next cycle TX=1, RTS=0, busy=0, no done; a new send then sends a clean full frame.
- ack held high after done -> state stays RELEASE and send is ignored; ack=0 -> IDLE the next cycle, and send is accepted again.
